// File: rtl/simon_pkg.sv
// Shared constants, state encoding and button helpers for the Simon game datapath.
package simon_pkg;

  localparam int COLOUR_W  = 2;
  localparam int SEQ_W     = 32;
  localparam int ROUND_W   = 4;
  localparam int MAX_ROUND = 15;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [COLOUR_W-1:0] colour_of(input logic [3:0] v);
    logic [COLOUR_W-1:0] c;
    c = 2'd0;
    case (v)
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for the four colour buttons.
// stable_pulse marks the cycle in which a newly stable level becomes visible on stable_val.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] btn_in,
  output logic [3:0] stable_val,
  output logic       stable_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The cycle that loads a new candidate already counts as its first stable cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [3:0]       sync1, sync2, cand, held;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
      cand  <= 4'd0;
      held  <= 4'd0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CNT_LOAD;
      end else if (clear) begin
        cnt <= CNT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Clearing adopts the current candidate, so a level already present is never reported as new.
      if (clear || stable_pulse)
        held <= cand;
    end
  end

  assign stable_pulse = (cnt == '0) && (sync2 == cand) && (cand != held);
  assign stable_val   = stable_pulse ? cand : held;

endmodule

// File: rtl/input_state.sv
// Collects round+1 debounced colour presses, packs them LSB-first and hands them to check_state.
// state        | meaning
// IDLE         | waiting for en_input, outputs hold last sequence
// WAIT_PRESS   | waiting for a stable one-hot press, idle timer running
// WAIT_RELEASE | press recorded, waiting for stable all-zero
// DONE         | sequence complete, en_check high this cycle
module input_state
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000
) (
  input  logic                clk,
  input  logic                rst_input,
  input  logic                en_input,
  input  logic [3:0]          btn_in,
  input  logic [ROUND_W-1:0]  round_ctr_in,
  output logic [SEQ_W-1:0]    seq_in_check,
  output logic                en_check,
  output logic                press_valid,
  output logic [COLOUR_W-1:0] press_colour,
  output logic                timeout,
  output logic                busy
);

  state_t             state;
  logic [ROUND_W-1:0] idx, n_lat;
  logic [31:0]        timer;
  logic [3:0]         deb_val;
  logic               deb_pulse, deb_clr, press_ok, rel_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk          (clk),
    .rst          (rst_input),
    .clear        (deb_clr),
    .btn_in       (btn_in),
    .stable_val   (deb_val),
    .stable_pulse (deb_pulse)
  );

  assign press_ok = deb_pulse && is_onehot4(deb_val);
  assign rel_ok   = deb_pulse && (deb_val == 4'd0);

  // Restart debouncing on every entry to a collecting state.
  always_comb begin
    deb_clr = 1'b0;
    case (state)
      IDLE:         deb_clr = en_input;
      WAIT_PRESS:   deb_clr = press_ok;
      WAIT_RELEASE: deb_clr = rel_ok && (idx != n_lat);
      default:      deb_clr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_input) begin
    if (rst_input) begin
      state        <= IDLE;
      seq_in_check <= '0;
      idx          <= '0;
      n_lat        <= '0;
      timer        <= '0;
      en_check     <= 1'b0;
      press_valid  <= 1'b0;
      press_colour <= '0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      en_check    <= 1'b0;
      press_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (en_input) begin
            seq_in_check <= '0;
            idx          <= '0;
            timer        <= '0;
            n_lat        <= round_ctr_in;
            busy         <= 1'b1;
            state        <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (press_ok) begin
            seq_in_check[{idx, 1'b0} +: COLOUR_W] <= colour_of(deb_val);
            press_colour <= colour_of(deb_val);
            press_valid  <= 1'b1;
            timer        <= '0;
            state        <= WAIT_RELEASE;
          end else if (timer == TIMEOUT_CYCLES - 32'd1) begin
            timeout <= 1'b1;
            timer   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        WAIT_RELEASE: begin
          if (rel_ok) begin
            if (idx == n_lat) begin
              en_check <= 1'b1;
              state    <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= WAIT_PRESS;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_state.sv
// Directed bench for input_state: vector table of full rounds plus hand-written corner sequences.
module tb_input_state;

  logic        clk = 1'b0;
  logic        rst_input;
  logic        en_input;
  logic [3:0]  btn_in;
  logic [3:0]  round_ctr_in;
  logic [31:0] seq_in_check;
  logic        en_check;
  logic        press_valid;
  logic [1:0]  press_colour;
  logic        timeout;
  logic        busy;

  input_state #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32'd50)) dut (
    .clk          (clk),
    .rst_input    (rst_input),
    .en_input     (en_input),
    .btn_in       (btn_in),
    .round_ctr_in (round_ctr_in),
    .seq_in_check (seq_in_check),
    .en_check     (en_check),
    .press_valid  (press_valid),
    .press_colour (press_colour),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_pv = 0, n_en = 0, n_to = 0;
  logic [31:0] seq_at_en = 32'd0;

  always @(posedge clk) begin
    if (press_valid) n_pv++;
    if (en_check) begin
      n_en++;
      seq_at_en = seq_in_check;
    end
    if (timeout) n_to++;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  n;
    logic [63:0] btns;      // press i uses btns[4i+3:4i]
    logic [31:0] exp_seq;
    logic [1:0]  exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic start_round(input logic [3:0] n);
    round_ctr_in = n;
    en_input = 1'b1;
    @(negedge clk);
    en_input = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn_in = b;
    repeat (10) @(negedge clk);
    btn_in = 4'd0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int pv0, en0, to0;
    pv0 = n_pv; en0 = n_en; to0 = n_to;
    start_round(v.n);
    for (int i = 0; i <= int'(v.n); i++) begin
      if (i == 5) round_ctr_in = 4'd1;
      press(v.btns[4*i +: 4]);
    end
    wait_idle();
    chk({tag, "_seq"}, seq_in_check, v.exp_seq);
    chk({tag, "_seq_at_en"}, seq_at_en, v.exp_seq);
    chk({tag, "_presses"}, 32'(n_pv - pv0), 32'(v.n) + 32'd1);
    chk({tag, "_en_check"}, 32'(n_en - en0), 32'd1);
    chk({tag, "_timeout"}, 32'(n_to - to0), 32'd0);
    chk({tag, "_colour"}, 32'(press_colour), 32'(v.exp_last));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, pv0, en0, to0;

    vecs[0] = '{n: 4'd0,  btns: 64'h4,                   exp_seq: 32'h0000_0002, exp_last: 2'd2};
    vecs[1] = '{n: 4'd3,  btns: 64'h4821,                exp_seq: 32'h0000_00B4, exp_last: 2'd2};
    vecs[2] = '{n: 4'd15, btns: 64'h8888_8888_8888_8888, exp_seq: 32'hFFFF_FFFF, exp_last: 2'd3};
    vecs[3] = '{n: 4'd1,  btns: 64'h12,                  exp_seq: 32'h0000_0001, exp_last: 2'd0};
    vecs[4] = '{n: 4'd2,  btns: 64'h418,                 exp_seq: 32'h0000_0023, exp_last: 2'd2};
    vecs[5] = '{n: 4'd1,  btns: 64'h84,                  exp_seq: 32'h0000_000E, exp_last: 2'd3};

    rst_input = 1'b1; en_input = 1'b0; btn_in = 4'd0; round_ctr_in = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_seq", seq_in_check, 32'd0);
    chk("reset_flags", {26'd0, en_check, press_valid, press_colour, timeout, busy}, 32'd0);
    rst_input = 1'b0;
    @(negedge clk);

    // First press latency: 2 sync + 4 debounce cycles.
    en0 = n_en;
    start_round(4'd0);
    btn_in = 4'b0100;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (press_valid) lat = k;
    end
    chk("press_latency", 32'(lat), 32'd6);
    repeat (4) @(negedge clk);
    btn_in = 4'd0;
    wait_idle();
    chk("lat_seq", seq_in_check, 32'h2);
    chk("lat_en_check", 32'(n_en - en0), 32'd1);
    chk("lat_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Bouncing button gives exactly one press.
    pv0 = n_pv; en0 = n_en;
    start_round(4'd0);
    for (int i = 0; i < 5; i++) begin
      btn_in = 4'b0100; repeat (2) @(negedge clk);
      btn_in = 4'b0000; repeat (2) @(negedge clk);
    end
    chk("bounce_no_early_press", 32'(n_pv - pv0), 32'd0);
    press(4'b0100);
    wait_idle();
    chk("bounce_presses", 32'(n_pv - pv0), 32'd1);
    chk("bounce_seq", seq_in_check, 32'h2);
    chk("bounce_en_check", 32'(n_en - en0), 32'd1);

    // Multi-hot is never a press.
    pv0 = n_pv; en0 = n_en;
    start_round(4'd0);
    btn_in = 4'b0011;
    repeat (15) @(negedge clk);
    chk("multihot_presses", 32'(n_pv - pv0), 32'd0);
    btn_in = 4'd0;
    repeat (10) @(negedge clk);
    press(4'b0001);
    wait_idle();
    chk("multihot_then_press", 32'(n_pv - pv0), 32'd1);
    chk("multihot_seq", seq_in_check, 32'h0);
    chk("multihot_en_check", 32'(n_en - en0), 32'd1);

    // Timeout with no presses: pulse 50 cycles after entry.
    en0 = n_en; to0 = n_to;
    start_round(4'd0);
    lat = 0;
    for (int k = 1; k <= 70 && lat == 0; k++) begin
      @(negedge clk);
      if (timeout) lat = k;
    end
    chk("timeout_latency", 32'(lat), 32'd50);
    @(negedge clk);
    chk("timeout_count", 32'(n_to - to0), 32'd1);
    chk("timeout_no_en_check", 32'(n_en - en0), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);

    // Timeout after a partial round keeps the partial sequence.
    en0 = n_en; to0 = n_to;
    start_round(4'd2);
    press(4'b0010);
    for (int k = 0; k < 70 && n_to == to0; k++) @(negedge clk);
    chk("partial_timeout_count", 32'(n_to - to0), 32'd1);
    chk("partial_seq_kept", seq_in_check, 32'h1);
    chk("partial_no_en_check", 32'(n_en - en0), 32'd0);
    chk("partial_busy", 32'(busy), 32'd0);

    // Button held across the handoff into a new round is not a press.
    pv0 = n_pv;
    btn_in = 4'b0001;
    repeat (8) @(negedge clk);
    start_round(4'd0);
    repeat (15) @(negedge clk);
    chk("held_not_counted", 32'(n_pv - pv0), 32'd0);
    btn_in = 4'd0;
    repeat (10) @(negedge clk);
    press(4'b0010);
    wait_idle();
    chk("held_then_seq", seq_in_check, 32'h1);
    chk("held_then_presses", 32'(n_pv - pv0), 32'd1);

    // Reset in WAIT_RELEASE of the second press.
    pv0 = n_pv;
    start_round(4'd3);
    press(4'b0010);
    btn_in = 4'b0100;
    for (int k = 0; k < 20 && (n_pv - pv0) < 2; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pre_reset_seq", seq_in_check, 32'h9);
    rst_input = 1'b1;
    #1;
    chk("midreset_seq", seq_in_check, 32'd0);
    chk("midreset_flags", {26'd0, en_check, press_valid, press_colour, timeout, busy}, 32'd0);
    btn_in = 4'd0;
    repeat (3) @(negedge clk);
    rst_input = 1'b0;
    @(negedge clk);
    run_vec(vecs[5], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
